// File: rtl/softmax_pkg.sv
// Shared FP16 definitions for the softmax exponent unit: field layout, operand type
// and the lane-index width helper.
package softmax_pkg;

    localparam int          FP16_EXP_BIAS = 15;
    localparam int unsigned FP16_EXP_MSB  = 14;
    localparam int unsigned FP16_EXP_LSB  = 10;
    localparam int unsigned FP16_MAN_MSB  = 9;
    localparam int unsigned FP16_MAN_LSB  = 0;
    localparam int unsigned FP16_MAN_W    = 10;

    typedef logic [15:0] fp16_t;

    function automatic int unsigned lane_idx_w(input int unsigned n);
        return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/fp16_fixed_sched_if.sv
// Request/result bundle between the softmax lanes, the shared FP16-to-fixed scheduler
// and the downstream exp LUT stage.
interface fp16_fixed_sched_if
    import softmax_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned INT_W     = 3,
    parameter int unsigned FRAC_W    = 3
);
    localparam int unsigned FX_W   = INT_W + FRAC_W;
    localparam int unsigned LANE_W = lane_idx_w(NUM_LANES);

    logic [NUM_LANES-1:0]    req_valid;
    logic [NUM_LANES*16-1:0] req_fp;
    logic [NUM_LANES-1:0]    req_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [FX_W-1:0]         out_fx;
    logic [LANE_W-1:0]       out_lane;
    logic                    out_sat;

    modport master (
        output req_valid, req_fp, out_ready,
        input  req_ready, out_valid, out_fx, out_lane, out_sat
    );

    modport slave (
        input  req_valid, req_fp, out_ready,
        output req_ready, out_valid, out_fx, out_lane, out_sat
    );

endinterface

// File: rtl/fp16_fixed_conv.sv
// Combinational FP16 magnitude to unsigned INT_W.FRAC_W fixed point, truncating,
// with overflow (including inf/NaN) saturating to all ones.
module fp16_fixed_conv
    import softmax_pkg::*;
#(
    parameter int unsigned INT_W  = 3,
    parameter int unsigned FRAC_W = 3
) (
    input  fp16_t                    fp,
    output logic [INT_W+FRAC_W-1:0]  fx,
    output logic                     sat
);
    localparam int unsigned      FX_W   = INT_W + FRAC_W;
    localparam logic signed [7:0] MAX_E  = $signed(8'(INT_W - 1));
    localparam logic signed [7:0] FRAC_S = $signed(8'(FRAC_W));
    localparam logic signed [7:0] MAN_S  = $signed(8'(FP16_MAN_W));
    localparam logic signed [7:0] BIAS_S = $signed(8'(FP16_EXP_BIAS));

    logic              sign_unused_s;
    logic [4:0]        exp_s;
    logic signed [7:0] e_s;
    logic signed [7:0] sh_s;
    logic [7:0]        rsh_s;
    logic [31:0]       mant_s;

    assign sign_unused_s = fp[15];

    // Value = 1.m * 2^E; in units of 2^-FRAC_W that is mant11 shifted by E - 10 + FRAC_W.
    always_comb begin
        exp_s  = fp[FP16_EXP_MSB:FP16_EXP_LSB];
        e_s    = $signed({3'b000, exp_s}) - BIAS_S;
        sh_s   = e_s - MAN_S + FRAC_S;
        rsh_s  = 8'(-sh_s);
        mant_s = {21'b0, 1'b1, fp[FP16_MAN_MSB:FP16_MAN_LSB]};
        fx     = '0;
        sat    = 1'b0;
        if (fp[14:0] == 15'd0) begin
            fx  = '0;
            sat = 1'b0;
        end else if (e_s > MAX_E) begin
            fx  = '1;
            sat = 1'b1;
        end else if (sh_s >= 8'sd0) begin
            fx  = FX_W'(mant_s << sh_s[4:0]);
            sat = 1'b0;
        end else begin
            fx  = FX_W'(mant_s >> rsh_s);
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/fp16_fixed_sched.sv
// Round-robin scheduler feeding one shared FP16-to-fixed converter: S0 grant/capture,
// S1 convert, S2 output register. Optional per-lane saturation counters: FP16_SAT_STATS_EN.
module fp16_fixed_sched
    import softmax_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned INT_W     = 3,
    parameter int unsigned FRAC_W    = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    fp16_fixed_sched_if.slave       bus
`ifdef FP16_SAT_STATS_EN
    ,
    output logic [NUM_LANES*16-1:0] sat_cnt
`endif
);
    localparam int unsigned FX_W   = INT_W + FRAC_W;
    localparam int unsigned LANE_W = lane_idx_w(NUM_LANES);

    logic [LANE_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                 s1_valid_q, s1_valid_d;
    fp16_t                s1_fp_q, s1_fp_d;
    logic [LANE_W-1:0]    s1_lane_q, s1_lane_d;
    logic                 out_valid_q, out_valid_d;
    logic [FX_W-1:0]      out_fx_q, out_fx_d;
    logic [LANE_W-1:0]    out_lane_q, out_lane_d;
    logic                 out_sat_q, out_sat_d;

    logic                 stall_s;
    logic                 grant_any_s;
    logic [LANE_W-1:0]    grant_idx_s;
    logic [NUM_LANES-1:0] grant_s;
    logic [FX_W-1:0]      conv_fx_s;
    logic                 conv_sat_s;

    assign stall_s = out_valid_q & ~bus.out_ready;

    // First requesting lane at or after rr_ptr wins; nobody wins while stalled.
    always_comb begin
        logic [LANE_W-1:0] idx;
        logic              hit;
        idx         = '0;
        hit         = 1'b0;
        grant_s     = '0;
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            idx          = LANE_W'((32'(rr_ptr_q) + 32'(i)) % 32'(NUM_LANES));
            hit          = ~grant_any_s & ~stall_s & bus.req_valid[idx];
            grant_s[idx] = hit;
            grant_idx_s  = hit ? idx : grant_idx_s;
            grant_any_s  = grant_any_s | hit;
        end
    end

    // Pipeline advance; the whole pipe freezes as a unit so no bubble is removed.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_fp_d     = s1_fp_q;
        s1_lane_d   = s1_lane_q;
        out_valid_d = out_valid_q;
        out_fx_d    = out_fx_q;
        out_lane_d  = out_lane_q;
        out_sat_d   = out_sat_q;
        if (stall_s) begin
            rr_ptr_d = rr_ptr_q;
        end else begin
            s1_valid_d  = grant_any_s;
            out_valid_d = s1_valid_q;
            if (grant_any_s) begin
                s1_fp_d   = bus.req_fp[{grant_idx_s, 4'b0000} +: 16];
                s1_lane_d = grant_idx_s;
                rr_ptr_d  = LANE_W'((32'(grant_idx_s) + 32'd1) % 32'(NUM_LANES));
            end else begin
                rr_ptr_d  = rr_ptr_q;
            end
            if (s1_valid_q) begin
                out_fx_d   = conv_fx_s;
                out_lane_d = s1_lane_q;
                out_sat_d  = conv_sat_s;
            end else begin
                out_sat_d  = out_sat_q;
            end
        end
    end

    // State registers; reset drops every in-flight operand.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_fp_q     <= 16'h0000;
            s1_lane_q   <= '0;
            out_valid_q <= 1'b0;
            out_fx_q    <= '0;
            out_lane_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_fp_q     <= s1_fp_d;
            s1_lane_q   <= s1_lane_d;
            out_valid_q <= out_valid_d;
            out_fx_q    <= out_fx_d;
            out_lane_q  <= out_lane_d;
            out_sat_q   <= out_sat_d;
        end
    end

    fp16_fixed_conv #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_conv (
        .fp  (s1_fp_q),
        .fx  (conv_fx_s),
        .sat (conv_sat_s)
    );

    assign bus.req_ready = grant_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_fx    = out_fx_q;
    assign bus.out_lane  = out_lane_q;
    assign bus.out_sat   = out_sat_q;

`ifdef FP16_SAT_STATS_EN
    logic [NUM_LANES-1:0][15:0] sat_cnt_q, sat_cnt_d;

    // Count saturated results on pop, sticking at full scale.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (out_valid_q && bus.out_ready && out_sat_q && (sat_cnt_q[out_lane_q] != 16'hFFFF)) begin
            sat_cnt_d[out_lane_q] = sat_cnt_q[out_lane_q] + 16'd1;
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // Saturation counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fp16_fixed_sched.sv
// Directed bench for fp16_fixed_sched: conversion table, reset flush, round-robin
// order under full traffic, and backpressure hold/resume.
module tb_fp16_fixed_sched;

    localparam int unsigned NL = 4;
    localparam int unsigned IW = 3;
    localparam int unsigned FW = 3;
    localparam int          NV = 14;

    typedef struct {
        logic [1:0]  lane;
        logic [15:0] fp;
        logic [5:0]  fx;
        logic        sat;
    } vec_t;

    typedef struct {
        logic [1:0] lane;
        logic [5:0] fx;
    } sb_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fp16_fixed_sched_if #(.NUM_LANES(NL), .INT_W(IW), .FRAC_W(FW)) bus ();

`ifdef FP16_SAT_STATS_EN
    logic [NL*16-1:0] sat_cnt;
`endif

    fp16_fixed_sched #(.NUM_LANES(NL), .INT_W(IW), .FRAC_W(FW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef FP16_SAT_STATS_EN
        ,
        .sat_cnt (sat_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t        vecs [NV];
    logic [15:0] lane_fp [4];
    logic [5:0]  lane_fx [4];
    sb_t         exp_q [$];
    sb_t         item;
    logic [3:0]  oh;
    logic        rdy;
    int          gk;
    int          n_in;
    int          n_out;

    initial begin
        vecs[0]  = '{2'd0, 16'h3C00, 6'd8,  1'b0};
        vecs[1]  = '{2'd2, 16'h4C00, 6'd63, 1'b1};
        vecs[2]  = '{2'd2, 16'h0000, 6'd0,  1'b0};
        vecs[3]  = '{2'd2, 16'h8000, 6'd0,  1'b0};
        vecs[4]  = '{2'd1, 16'h2C00, 6'd0,  1'b0};
        vecs[5]  = '{2'd3, 16'h3A00, 6'd6,  1'b0};
        vecs[6]  = '{2'd1, 16'hBC00, 6'd8,  1'b0};
        vecs[7]  = '{2'd0, 16'h7C00, 6'd63, 1'b1};
        vecs[8]  = '{2'd3, 16'h4400, 6'd32, 1'b0};
        vecs[9]  = '{2'd0, 16'h47FF, 6'd63, 1'b0};
        vecs[10] = '{2'd1, 16'h3400, 6'd2,  1'b0};
        vecs[11] = '{2'd2, 16'h3000, 6'd1,  1'b0};
        vecs[12] = '{2'd3, 16'h2FFF, 6'd0,  1'b0};
        vecs[13] = '{2'd1, 16'h4800, 6'd63, 1'b1};
        lane_fp[0] = 16'h3C00; lane_fx[0] = 6'd8;
        lane_fp[1] = 16'h4000; lane_fx[1] = 6'd16;
        lane_fp[2] = 16'h4200; lane_fx[2] = 6'd24;
        lane_fp[3] = 16'h3800; lane_fx[3] = 6'd4;

        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_fp    = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_fx",    32'(bus.out_fx),    32'd0);
        chk("rst_out_lane",  32'(bus.out_lane),  32'd0);
        chk("rst_out_sat",   32'(bus.out_sat),   32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
`ifdef FP16_SAT_STATS_EN
        chk("rst_sat_cnt",   32'(sat_cnt == '0), 32'd1);
`endif
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Single-operand conversions with exact two-cycle latency.
        for (int k = 0; k < NV; k++) begin
            oh            = 4'b0001 << vecs[k].lane;
            bus.req_valid = oh;
            bus.req_fp    = {4{vecs[k].fp}};
            #1;
            chk($sformatf("vec%0d_ready", k), 32'(bus.req_ready), 32'(oh));
            tick();
            bus.req_valid = '0;
            #1;
            chk($sformatf("vec%0d_lat1_valid", k), 32'(bus.out_valid), 32'd0);
            tick();
            #1;
            chk($sformatf("vec%0d_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_fx", k),    32'(bus.out_fx),    32'(vecs[k].fx));
            chk($sformatf("vec%0d_lane", k),  32'(bus.out_lane),  32'(vecs[k].lane));
            chk($sformatf("vec%0d_sat", k),   32'(bus.out_sat),   32'(vecs[k].sat));
            @(negedge clk);
        end
        tick();
`ifdef FP16_SAT_STATS_EN
        chk("sat_cnt_lane0", 32'(sat_cnt[15:0]),  32'd1);
        chk("sat_cnt_lane1", 32'(sat_cnt[31:16]), 32'd1);
        chk("sat_cnt_lane2", 32'(sat_cnt[47:32]), 32'd1);
        chk("sat_cnt_lane3", 32'(sat_cnt[63:48]), 32'd0);
`endif

        // Two operands in flight, then reset.
        bus.req_valid = 4'b0110;
        bus.req_fp    = {4{16'h3C00}};
        tick();
        tick();
        bus.req_valid = '0;
        #1;
        chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_async_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_async_fx",    32'(bus.out_fx),    32'd0);
        chk("reset_async_lane",  32'(bus.out_lane),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("post_reset_valid%0d", c), 32'(bus.out_valid), 32'd0);
        end

        // Full traffic on every lane, with a five-cycle backpressure window.
        for (int l = 0; l < 4; l++) begin
            bus.req_fp[16*l +: 16] = lane_fp[l];
        end
        bus.req_valid = '1;
        gk    = 0;
        n_in  = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            rdy           = !(cyc >= 8 && cyc < 13);
            bus.out_ready = rdy;
            #1;
            chk($sformatf("rr%0d_out_valid", cyc), 32'(bus.out_valid), 32'(cyc >= 2));
            if (cyc >= 2) begin
                chk($sformatf("rr%0d_sb_nonempty", cyc), 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    item = exp_q[0];
                    chk($sformatf("rr%0d_out_lane", cyc), 32'(bus.out_lane), 32'(item.lane));
                    chk($sformatf("rr%0d_out_fx", cyc),   32'(bus.out_fx),   32'(item.fx));
                    chk($sformatf("rr%0d_out_sat", cyc),  32'(bus.out_sat),  32'd0);
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            oh = rdy ? (4'b0001 << 2'(gk % 4)) : 4'b0000;
            chk($sformatf("rr%0d_req_ready", cyc), 32'(bus.req_ready), 32'(oh));
            if (rdy) begin
                item.lane = 2'(gk % 4);
                item.fx   = lane_fx[gk % 4];
                exp_q.push_back(item);
                gk++;
                n_in++;
            end
            tick();
        end

        // Drain what remains in the pipe.
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.out_valid) begin
                chk($sformatf("drain%0d_sb_nonempty", c), 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    item = exp_q.pop_front();
                    chk($sformatf("drain%0d_out_lane", c), 32'(bus.out_lane), 32'(item.lane));
                    chk($sformatf("drain%0d_out_fx", c),   32'(bus.out_fx),   32'(item.fx));
                    n_out++;
                end
            end
            tick();
        end
        chk("drain_empty",       32'(exp_q.size()),    32'd0);
        chk("count_in_eq_out",   32'(n_out),           32'(n_in));
        chk("final_out_valid",   32'(bus.out_valid),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
